// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: host-to-device PS/2 byte transmitter (request, shift, ACK check).
// Ports: clk, rst (async high), PS2_clk/PS2_data pad read-back, tx_data/tx_valid/
// tx_ready/tx_busy request side, PS2_clk_oe/PS2_data_oe open-drain pulls,
// tx_done/tx_error result pulses. Optional macro PS2_TX_RESEND_EN adds 2 retries.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int M1 = (INHIBIT_CYCLES > REQ_CYCLES) ?
                      INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MX = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQUEST   = 3'd2;
  localparam logic [2:0] S_TRANSFER  = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    n;
  logic [9:0]    frame;
  logic          clk_meta, clk_s, clk_q;
  logic          data_meta, data_s;
  logic          fe, at_to, nack, tmo, fail;
`ifdef PS2_TX_RESEND_EN
  logic [1:0]    retry;
`endif

  // Synchronisers start at the idle-high bus level so reset
  // release never fakes a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_q     <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= PS2_clk;
      clk_s     <= clk_meta;
      clk_q     <= clk_s;
      data_meta <= PS2_data;
      data_s    <= data_meta;
    end
  end

  assign fe    = clk_q & ~clk_s;
  assign at_to = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign nack  = (state == S_TRANSFER) && fe &&
                 (n == 4'd10) && data_s;
  // A device edge on the terminal count wins over the timeout.
  assign tmo   = at_to && !fe &&
                 ((state == S_TRANSFER) ||
                  ((state == S_WAIT_IDLE) && !(clk_s && data_s)));
  assign fail  = nack || tmo;

  assign tx_busy = ~tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      n           <= '0;
      frame       <= '0;
      tx_ready    <= 1'b1;
      PS2_clk_oe  <= 1'b0;
      PS2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry       <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            // Shift frame: stop, odd parity, d7..d0 (sent LSB first).
            frame       <= {1'b1, ~^tx_data, tx_data};
            cnt         <= '0;
            state       <= S_INHIBIT;
            tx_ready    <= 1'b0;
            PS2_clk_oe  <= 1'b1;
            PS2_data_oe <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            retry       <= '0;
`endif
          end
        end
        S_INHIBIT: begin
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            cnt         <= '0;
            state       <= S_REQUEST;
            PS2_data_oe <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REQUEST: begin
          if (cnt == CW'(REQ_CYCLES - 1)) begin
            cnt        <= '0;
            n          <= '0;
            state      <= S_TRANSFER;
            PS2_clk_oe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TRANSFER: begin
          if (fe) begin
            cnt <= '0;
            n   <= n + 4'd1;
            if (n == 4'd10) begin
              state <= S_WAIT_IDLE;
            end else begin
              PS2_data_oe <= ~frame[n];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            state   <= S_DONE;
            tx_done <= 1'b1;
          end else if (fe) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          state    <= S_IDLE;
          tx_ready <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          tx_ready    <= 1'b1;
          PS2_clk_oe  <= 1'b0;
          PS2_data_oe <= 1'b0;
        end
      endcase

      if (fail) begin
`ifdef PS2_TX_RESEND_EN
        if (retry == 2'd2) begin
          state       <= S_ERROR;
          tx_error    <= 1'b1;
          PS2_clk_oe  <= 1'b0;
          PS2_data_oe <= 1'b0;
        end else begin
          // Same byte again from a fresh inhibit phase.
          retry       <= retry + 2'd1;
          state       <= S_INHIBIT;
          cnt         <= '0;
          PS2_clk_oe  <= 1'b1;
          PS2_data_oe <= 1'b0;
        end
`else
        state       <= S_ERROR;
        tx_error    <= 1'b1;
        PS2_clk_oe  <= 1'b0;
        PS2_data_oe <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a behavioural
// PS/2 device on open-drain pads; frames compared with a byte-level model.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int REQ  = 16;
  localparam int TO   = 2000;
  localparam int HALF = 40;
`ifdef PS2_TX_RESEND_EN
  localparam int NTRY = 3;
`else
  localparam int NTRY = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, PS2_clk_oe, PS2_data_oe;
  logic       tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       pad_clk, pad_data;

  assign pad_clk  = ~(PS2_clk_oe | dev_clk_low);
  assign pad_data = ~(PS2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(REQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PS2_clk(pad_clk),
    .PS2_data(pad_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .PS2_clk_oe(PS2_clk_oe),
    .PS2_data_oe(PS2_data_oe),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  // Monitors.
  int   cyc = 0;
  int   done_n = 0, err_n = 0, inh_n = 0, busy_bad = 0;
  int   clk_run = 0, req_run = 0, last_inh = 0, last_req = 0;
  int   err_cyc = 0;
  logic prev_clk_oe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_n <= done_n + 1;
    if (tx_error) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (tx_busy !== ~tx_ready) busy_bad <= busy_bad + 1;
    if (PS2_clk_oe && !prev_clk_oe) begin
      inh_n   <= inh_n + 1;
      clk_run <= 1;
      req_run <= PS2_data_oe ? 1 : 0;
    end else if (PS2_clk_oe) begin
      clk_run <= clk_run + 1;
      if (PS2_data_oe) req_run <= req_run + 1;
    end
    if (!PS2_clk_oe && prev_clk_oe) begin
      last_inh <= clk_run;
      last_req <= req_run;
    end
    prev_clk_oe <= PS2_clk_oe;
  end

  // Device model: 0 = ACK, 1 = NACK, 2 = stop clocking after edge 4.
  int         dev_mode = 0;
  bit         dev_abort = 1'b0;
  int         dev_edges = 0;
  int         dev_last_fall = 0;
  logic [10:0] rx_q[$];
  logic [10:0] dev_fr;
  bit         dev_ok;

  task automatic dev_wait(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin : device
    forever begin
      wait (PS2_clk_oe === 1'b1);
      wait (PS2_clk_oe === 1'b0);
      if (pad_data === 1'b0) begin
        dev_edges = 0;
        dev_fr = '0;
        dev_ok = 1'b1;
        dev_wait(20);
        dev_fr[0] = pad_data;
        for (int k = 1; k <= 11; k++) begin
          if (dev_abort || (dev_mode == 2 && k == 5)) begin
            dev_ok = 1'b0;
            break;
          end
          dev_clk_low = 1'b1;
          dev_edges = k;
          dev_last_fall = cyc;
          dev_wait(HALF);
          dev_clk_low = 1'b0;
          if (k <= 10) dev_fr[k] = pad_data;
          if (k == 10 && dev_mode == 0) dev_data_low = 1'b1;
          dev_wait(HALF);
        end
        dev_clk_low = 1'b0;
        dev_wait(5);
        dev_data_low = 1'b0;
        if (dev_ok) rx_q.push_back(dev_fr);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    while (!tx_ready && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("send_ready", 32'(t < 5000), 32'd1);
    tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] b, input int mode,
                          output int t);
    int d0, e0;
    d0 = done_n;
    e0 = err_n;
    t = 0;
    dev_mode = mode;
    send(b);
    while (done_n == d0 && err_n == e0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ack_xfer(input string tag, input logic [7:0] b,
                          output logic [10:0] fr);
    int d0, e0, n0, t;
    d0 = done_n;
    e0 = err_n;
    n0 = rx_q.size();
    run_xfer(b, 0, t);
    check({tag, "_end"}, 32'(t < 20000), 32'd1);
    check({tag, "_done"}, 32'(done_n - d0), 32'd1);
    check({tag, "_err"}, 32'(err_n - e0), 32'd0);
    check({tag, "_rdy"}, 32'(tx_ready), 32'd1);
    check({tag, "_inh"}, 32'(last_inh), 32'(INH + REQ));
    check({tag, "_req"}, 32'(last_req), 32'(REQ));
    check({tag, "_nfr"}, 32'(rx_q.size() - n0), 32'd1);
    fr = '1;
    if (rx_q.size() > n0) begin
      fr = rx_q[n0];
      check({tag, "_frame"}, 32'(fr), 32'(exp_frame(b)));
    end
  endtask

  logic [7:0] acc_q[$];

  initial begin
    logic [10:0] fr;
    int d0, e0, i0, n0, t, acc, last_done, gap, dly;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_oe", 32'(PS2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(PS2_data_oe), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);

    ack_xfer("ed", 8'hED, fr);
    check("ed_par", 32'(fr[9]), 32'd1);
    check("ed_stop", 32'(fr[10]), 32'd1);
    ack_xfer("x00", 8'h00, fr);
    check("x00_par", 32'(fr[9]), 32'd1);
    ack_xfer("xff", 8'hFF, fr);
    check("xff_par", 32'(fr[9]), 32'd1);
    ack_xfer("x01", 8'h01, fr);
    check("x01_par", 32'(fr[9]), 32'd0);
    for (int i = 0; i < 4; i++) ack_xfer("rnd", 8'($urandom), fr);

    // NACK
    d0 = done_n; e0 = err_n; i0 = inh_n;
    run_xfer(8'($urandom), 1, t);
    check("nack_end", 32'(t < 20000), 32'd1);
    check("nack_err", 32'(err_n - e0), 32'd1);
    check("nack_done", 32'(done_n - d0), 32'd0);
    check("nack_inh", 32'(inh_n - i0), 32'(NTRY));
    check("nack_clk_oe", 32'(PS2_clk_oe), 32'd0);
    check("nack_data_oe", 32'(PS2_data_oe), 32'd0);
    check("nack_rdy", 32'(tx_ready), 32'd1);
    repeat (150) @(posedge clk);

    // Device stops clocking after edge 4
    d0 = done_n; e0 = err_n; i0 = inh_n;
    run_xfer(8'($urandom), 2, t);
    dly = err_cyc - dev_last_fall;
    check("to_end", 32'(t < 20000), 32'd1);
    check("to_err", 32'(err_n - e0), 32'd1);
    check("to_done", 32'(done_n - d0), 32'd0);
    check("to_inh", 32'(inh_n - i0), 32'(NTRY));
    check("to_delay", 32'(dly >= TO && dly <= TO + 4), 32'd1);
    check("to_clk_oe", 32'(PS2_clk_oe), 32'd0);
    check("to_data_oe", 32'(PS2_data_oe), 32'd0);
    repeat (150) @(posedge clk);

    // Reset during bit 5
    dev_mode = 0;
    send(8'hED);
    t = 0;
    while (dev_edges != 5 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("rst_reach_b5", 32'(t < 5000), 32'd1);
    repeat (10) @(posedge clk);
    #5;
    check("pre_rst_data_oe", 32'(PS2_data_oe), 32'd1);
    d0 = done_n; e0 = err_n;
    dev_abort = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_clk_oe", 32'(PS2_clk_oe), 32'd0);
    check("mid_rst_data_oe", 32'(PS2_data_oe), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("mid_rst_done", 32'(done_n - d0), 32'd0);
    check("mid_rst_err", 32'(err_n - e0), 32'd0);
    dev_abort = 1'b0;
    ack_xfer("f3", 8'hF3, fr);

    // tx_valid held high, data changing every cycle
    n0 = rx_q.size(); d0 = done_n;
    acc = 0; t = 0; last_done = -100; gap = -1;
    dev_mode = 0;
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data = 8'($urandom);
    while (acc < 2 && t < 20000) begin
      @(negedge clk);
      if (tx_done) last_done = t;
      if (tx_ready) begin
        acc_q.push_back(tx_data);
        acc++;
        if (acc == 2) gap = t - last_done;
      end
      @(posedge clk);
      #1;
      if (acc == 2) tx_valid = 1'b0;
      tx_data = 8'($urandom);
      t++;
    end
    check("hv_accepts", 32'(acc), 32'd2);
    check("hv_gap", 32'(gap), 32'd1);
    check("hv_rdy_drop", 32'(tx_ready), 32'd0);
    t = 0;
    while (done_n - d0 < 2 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("hv_done", 32'(done_n - d0), 32'd2);
    check("hv_nfr", 32'(rx_q.size() - n0), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (rx_q.size() > n0 + i && acc_q.size() > i)
        check("hv_frame", 32'(rx_q[n0 + i]), 32'(exp_frame(acc_q[i])));
    end

    check("busy_eq_not_ready", 32'(busy_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
